// File: rtl/bp_be_regfile_nr.sv
// Register file with synchronous reads, held-address re-read and write forwarding.
// Optional zeroing scrub after reset is enabled by BP_BE_REGFILE_SCRUB_EN.
module bp_be_regfile_nr #(
    parameter int width_p       = 64,
    parameter int els_p         = 32,
    parameter int read_ports_p  = 3,
    parameter int zero_reg_p    = 0,
    localparam int addr_width_lp = $clog2(els_p)
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    output logic                                  ready_o,
    input  logic                                  cfg_w_v_i,
    input  logic                                  cfg_r_v_i,
    input  logic [addr_width_lp-1:0]              cfg_addr_i,
    input  logic [width_p-1:0]                    cfg_data_i,
    output logic [width_p-1:0]                    cfg_data_o,
    input  logic                                  rd_w_v_i,
    input  logic [addr_width_lp-1:0]              rd_addr_i,
    input  logic [width_p-1:0]                    rd_data_i,
    input  logic [read_ports_p-1:0]               rs_r_v_i,
    input  logic [read_ports_p*addr_width_lp-1:0] rs_addr_i,
    output logic [read_ports_p*width_p-1:0]       rs_data_o
);

    typedef logic [addr_width_lp-1:0] addr_t;
    typedef logic [width_p-1:0]       data_t;

    data_t mem [els_p];

    addr_t held_q  [read_ports_p];
    addr_t eff     [read_ports_p];
    data_t rdata_q [read_ports_p];
    data_t fwd_data_q;
    data_t cfg_data_q;

    logic [read_ports_p-1:0] fwd_q;
    logic [read_ports_p-1:0] fwd_hit;

    logic  ready;
    logic  cfg_v;
    logic  cfg_we;
    logic  rd_we;
    logic  w_v;
    addr_t w_addr;
    data_t w_data;

    function automatic logic is_zero(input addr_t a);
        return (zero_reg_p != 0) && (a == '0);
    endfunction

`ifdef BP_BE_REGFILE_SCRUB_EN
    typedef enum logic [1:0] {
        e_reset,
        e_scrub,
        e_ready
    } state_e;

    state_e state_q;
    addr_t  cnt_q;
    logic   ready_q;

    // Scrub sequencer: zero every entry once after reset, then open the file.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_reset;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                e_reset: begin
                    state_q <= e_scrub;
                end
                e_scrub: begin
                    cnt_q <= cnt_q + addr_t'(1);
                    if (cnt_q == addr_t'(els_p - 1)) begin
                        state_q <= e_ready;
                        ready_q <= 1'b1;
                    end
                end
                e_ready: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= e_reset;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_q;
`else
    assign ready = ~reset_i;
`endif

    assign ready_o = ready;
    assign cfg_v   = cfg_w_v_i | cfg_r_v_i;
    assign cfg_we  = ready & cfg_w_v_i & ~is_zero(cfg_addr_i);
    assign rd_we   = ready & rd_w_v_i & ~cfg_w_v_i & ~is_zero(rd_addr_i);

    // Select the single write of the cycle: scrub, then config, then writeback.
    always_comb begin
        w_v    = 1'b0;
        w_addr = '0;
        w_data = '0;
`ifdef BP_BE_REGFILE_SCRUB_EN
        if (state_q == e_scrub) begin
            w_v    = 1'b1;
            w_addr = cnt_q;
        end else
`endif
        if (cfg_we) begin
            w_v    = 1'b1;
            w_addr = cfg_addr_i;
            w_data = cfg_data_i;
        end else if (rd_we) begin
            w_v    = 1'b1;
            w_addr = rd_addr_i;
            w_data = rd_data_i;
        end
    end

    // Effective address per port and writeback bypass detection.
    always_comb begin
        for (int i = 0; i < read_ports_p; i++) begin
            eff[i] = rs_r_v_i[i]
                   ? rs_addr_i[i*addr_width_lp +: addr_width_lp]
                   : held_q[i];
            fwd_hit[i] = rd_we & (rd_addr_i == eff[i]);
        end
    end

    // Storage array; no reset so it maps onto plain RAM cells.
    always_ff @(posedge clk_i) begin
        if (w_v) begin
            mem[w_addr] <= w_data;
        end
    end

    // Port pipeline: held addresses, registered reads, forward flags, config read.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fwd_q      <= '0;
            fwd_data_q <= '0;
            cfg_data_q <= '0;
            for (int i = 0; i < read_ports_p; i++) begin
                held_q[i]  <= '0;
                rdata_q[i] <= '0;
            end
        end else if (ready) begin
            for (int i = 0; i < read_ports_p; i++) begin
                if (rs_r_v_i[i]) begin
                    held_q[i] <= rs_addr_i[i*addr_width_lp +: addr_width_lp];
                end
            end
            if (!cfg_v) begin
                fwd_q <= fwd_hit;
                for (int i = 0; i < read_ports_p; i++) begin
                    rdata_q[i] <= is_zero(eff[i]) ? '0 : mem[eff[i]];
                end
                if (rd_we) begin
                    fwd_data_q <= rd_data_i;
                end
            end
            if (cfg_r_v_i) begin
                if (is_zero(cfg_addr_i)) begin
                    cfg_data_q <= '0;
                end else if (rd_we && (rd_addr_i == cfg_addr_i)) begin
                    cfg_data_q <= rd_data_i;
                end else begin
                    cfg_data_q <= mem[cfg_addr_i];
                end
            end
        end
    end

    // Forwarded data overrides the array read for flagged ports.
    always_comb begin
        rs_data_o = '0;
        for (int i = 0; i < read_ports_p; i++) begin
            rs_data_o[i*width_p +: width_p] = fwd_q[i] ? fwd_data_q : rdata_q[i];
        end
    end

    assign cfg_data_o = cfg_data_q;

endmodule

// File: tb/tb_bp_be_regfile_nr.sv
// Directed self-checking bench for bp_be_regfile_nr.
// Drives a normal file and a zero-register file in parallel.
module tb_bp_be_regfile_nr;

    localparam int W  = 64;
    localparam int AW = 5;
    localparam int P  = 3;

`ifdef BP_BE_REGFILE_SCRUB_EN
    localparam int READY_LAT = 33;
`else
    localparam int READY_LAT = 1;
`endif

    logic            clk = 1'b0;
    logic            reset_i;
    logic            cfg_w_v, cfg_r_v;
    logic [AW-1:0]   cfg_addr;
    logic [W-1:0]    cfg_data;
    logic            rd_w_v;
    logic [AW-1:0]   rd_addr;
    logic [W-1:0]    rd_data;
    logic [P-1:0]    rs_r_v;
    logic [P*AW-1:0] rs_addr;

    logic            ready0, readyz;
    logic [W-1:0]    cfg_out0, cfg_outz;
    logic [P*W-1:0]  rs0, rsz;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bp_be_regfile_nr #(.zero_reg_p(0)) u_dut (
        .clk_i(clk), .reset_i(reset_i), .ready_o(ready0),
        .cfg_w_v_i(cfg_w_v), .cfg_r_v_i(cfg_r_v),
        .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data), .cfg_data_o(cfg_out0),
        .rd_w_v_i(rd_w_v), .rd_addr_i(rd_addr), .rd_data_i(rd_data),
        .rs_r_v_i(rs_r_v), .rs_addr_i(rs_addr), .rs_data_o(rs0)
    );

    bp_be_regfile_nr #(.zero_reg_p(1)) u_zero (
        .clk_i(clk), .reset_i(reset_i), .ready_o(readyz),
        .cfg_w_v_i(cfg_w_v), .cfg_r_v_i(cfg_r_v),
        .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data), .cfg_data_o(cfg_outz),
        .rd_w_v_i(rd_w_v), .rd_addr_i(rd_addr), .rd_data_i(rd_data),
        .rs_r_v_i(rs_r_v), .rs_addr_i(rs_addr), .rs_data_o(rsz)
    );

    function automatic logic [W-1:0] port(input logic [P*W-1:0] v, input int i);
        return v[i*W +: W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic [AW-1:0] a, input logic [W-1:0] d);
        cfg_w_v = 1'b1; cfg_addr = a; cfg_data = d;
        tick();
        cfg_w_v = 1'b0;
    endtask

    task automatic cfg_rd(input logic [AW-1:0] a);
        cfg_r_v = 1'b1; cfg_addr = a;
        tick();
        cfg_r_v = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            n++;
            if (ready0) break;
        end
    endtask

    task automatic test_reset();
        int n;
        reset_i = 1'b1;
        tick(); tick();
        tests++;
        if (ready0 !== 1'b0 || readyz !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: got %b/%b want 0/0", ready0, readyz);
        end
        reset_i = 1'b0;
        wait_ready(n);
        tests++;
        if (n != READY_LAT || ready0 !== 1'b1) begin
            fails++;
            $display("FAIL ready_latency: got %0d (ready=%b) want %0d", n, ready0, READY_LAT);
        end
        cfg_wr(5'd0, 64'h77);
        tick();
        tests++;
        if (port(rs0, 0) !== 64'h77) begin
            fails++;
            $display("FAIL held_reset_p0: got %h want 77", port(rs0, 0));
        end
        tests++;
        if (port(rs0, 2) !== 64'h77) begin
            fails++;
            $display("FAIL held_reset_p2: got %h want 77", port(rs0, 2));
        end
        tests++;
        if (port(rsz, 0) !== 64'h0) begin
            fails++;
            $display("FAIL held_reset_zero: got %h want 0", port(rsz, 0));
        end
    endtask

    task automatic test_reset_abort();
        int n;
        logic [W-1:0] exp;
        cfg_wr(5'd5, 64'h5A);
        reset_i = 1'b1;
        rd_w_v = 1'b1; rd_addr = 5'd5; rd_data = 64'hFF;
        tick();
        rd_w_v = 1'b0;
        reset_i = 1'b0;
        wait_ready(n);
`ifdef BP_BE_REGFILE_SCRUB_EN
        exp = 64'h0;
`else
        exp = 64'h5A;
`endif
        cfg_rd(5'd5);
        tests++;
        if (cfg_out0 !== exp) begin
            fails++;
            $display("FAIL write_in_reset: got %h want %h", cfg_out0, exp);
        end
    endtask

`ifdef BP_BE_REGFILE_SCRUB_EN
    task automatic test_scrub();
        int n;
        logic ok;
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        wait_ready(n);
        tests++;
        if (n != 33) begin
            fails++;
            $display("FAIL scrub_latency: got %0d want 33", n);
        end
        for (int a = 0; a < 32; a++) begin
            cfg_rd(AW'(a));
            tests++;
            if (cfg_out0 !== 64'h0) begin
                fails++;
                $display("FAIL scrub_zero[%0d]: got %h want 0", a, cfg_out0);
            end
        end
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (ready0 !== 1'b0) ok = 1'b0;
        end
        reset_i = 1'b1;
        tick();
        tests++;
        if (!ok || ready0 !== 1'b0) begin
            fails++;
            $display("FAIL scrub_abort_low: got ok=%b ready=%b want 1/0", ok, ready0);
        end
        reset_i = 1'b0;
        wait_ready(n);
        tests++;
        if (n != 33) begin
            fails++;
            $display("FAIL scrub_restart: got %0d want 33", n);
        end
    endtask
`endif

    task automatic test_parallel();
        cfg_wr(5'd1, 64'h1);
        cfg_wr(5'd2, 64'h2);
        cfg_wr(5'd3, 64'h3);
        rs_r_v = 3'b111;
        rs_addr = {5'd3, 5'd2, 5'd1};
        tick();
        rs_r_v = 3'b000;
        rs_addr = {5'd9, 5'd9, 5'd9};
        tests++;
        if (rs0 !== {64'h3, 64'h2, 64'h1}) begin
            fails++;
            $display("FAIL parallel: got %h want 3/2/1", rs0);
        end
        tick();
        tests++;
        if (rs0 !== {64'h3, 64'h2, 64'h1}) begin
            fails++;
            $display("FAIL parallel_hold: got %h want 3/2/1", rs0);
        end
    endtask

    task automatic test_forward();
        cfg_wr(5'd7, 64'h1234);
        rd_w_v = 1'b1; rd_addr = 5'd7; rd_data = 64'hDEAD;
        rs_r_v = 3'b010;
        rs_addr = {5'd3, 5'd7, 5'd1};
        tick();
        rd_w_v = 1'b0;
        rs_r_v = 3'b000;
        tests++;
        if (port(rs0, 1) !== 64'hDEAD) begin
            fails++;
            $display("FAIL forward: got %h want dead", port(rs0, 1));
        end
        tests++;
        if (port(rs0, 0) !== 64'h1) begin
            fails++;
            $display("FAIL forward_other: got %h want 1", port(rs0, 0));
        end
        tick();
        tests++;
        if (port(rs0, 1) !== 64'hDEAD) begin
            fails++;
            $display("FAIL forward_mem: got %h want dead", port(rs0, 1));
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] exp [5];
        exp = '{64'h11, 64'h11, 64'h22, 64'h22, 64'h22};
        cfg_wr(5'd3, 64'h11);
        rs_r_v = 3'b001;
        rs_addr = {5'd0, 5'd0, 5'd3};
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                rd_w_v = 1'b1; rd_addr = 5'd3; rd_data = 64'h22;
            end
            tick();
            rs_r_v = 3'b000;
            rs_addr = {5'd0, 5'd0, 5'd9};
            rd_w_v = 1'b0;
            tests++;
            if (port(rs0, 0) !== exp[c]) begin
                fails++;
                $display("FAIL stall[%0d]: got %h want %h", c, port(rs0, 0), exp[c]);
            end
        end
    endtask

    task automatic test_priority();
        cfg_w_v = 1'b1; cfg_addr = 5'd4; cfg_data = 64'hAA;
        rd_w_v = 1'b1; rd_addr = 5'd4; rd_data = 64'hBB;
        tick();
        cfg_w_v = 1'b0;
        rd_w_v = 1'b0;
        cfg_rd(5'd4);
        tests++;
        if (cfg_out0 !== 64'hAA) begin
            fails++;
            $display("FAIL priority: got %h want aa", cfg_out0);
        end
        rd_w_v = 1'b1; rd_addr = 5'd4; rd_data = 64'hCC;
        tick();
        rd_w_v = 1'b0;
        cfg_rd(5'd4);
        tests++;
        if (cfg_out0 !== 64'hCC) begin
            fails++;
            $display("FAIL rd_write: got %h want cc", cfg_out0);
        end
    endtask

    task automatic test_zero();
        rd_w_v = 1'b1; rd_addr = 5'd0; rd_data = 64'h55;
        rs_r_v = 3'b111;
        rs_addr = {5'd0, 5'd0, 5'd0};
        tick();
        rd_w_v = 1'b0;
        rs_r_v = 3'b000;
        tests++;
        if (rsz !== '0) begin
            fails++;
            $display("FAIL zero_no_fwd: got %h want 0", rsz);
        end
        tests++;
        if (rs0 !== {3{64'h55}}) begin
            fails++;
            $display("FAIL nonzero_fwd0: got %h want 55x3", rs0);
        end
        tick();
        tests++;
        if (rsz !== '0) begin
            fails++;
            $display("FAIL zero_read: got %h want 0", rsz);
        end
        cfg_rd(5'd0);
        tests++;
        if (cfg_outz !== 64'h0 || cfg_out0 !== 64'h55) begin
            fails++;
            $display("FAIL zero_cfg_rd: got %h/%h want 0/55", cfg_outz, cfg_out0);
        end
        cfg_wr(5'd0, 64'h66);
        cfg_rd(5'd0);
        tests++;
        if (cfg_outz !== 64'h0) begin
            fails++;
            $display("FAIL zero_cfg_wr: got %h want 0", cfg_outz);
        end
        tests++;
        if (cfg_out0 !== 64'h66) begin
            fails++;
            $display("FAIL reg0_cfg_wr: got %h want 66", cfg_out0);
        end
    endtask

    task automatic test_multi_forward();
        rd_w_v = 1'b1; rd_addr = 5'd9; rd_data = 64'h99;
        rs_r_v = 3'b111;
        rs_addr = {5'd9, 5'd9, 5'd9};
        tick();
        rd_w_v = 1'b0;
        rs_r_v = 3'b000;
        tests++;
        if (rs0 !== {3{64'h99}}) begin
            fails++;
            $display("FAIL multi_fwd: got %h want 99x3", rs0);
        end
        tests++;
        if (rsz !== {3{64'h99}}) begin
            fails++;
            $display("FAIL multi_fwd_z: got %h want 99x3", rsz);
        end
    endtask

    initial begin
        reset_i  = 1'b1;
        cfg_w_v  = 1'b0;
        cfg_r_v  = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        rd_w_v   = 1'b0;
        rd_addr  = '0;
        rd_data  = '0;
        rs_r_v   = '0;
        rs_addr  = '0;
        test_reset();
        test_reset_abort();
`ifdef BP_BE_REGFILE_SCRUB_EN
        test_scrub();
`endif
        test_parallel();
        test_forward();
        test_stall();
        test_priority();
        test_zero();
        test_multi_forward();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
